// File: rtl/map_pkg.sv
// ============================================================================
// map_pkg : shared types for the OFDM pilot/data map consumers
// Rev 1.0
// ============================================================================
`default_nettype none

package map_pkg;

    localparam int IQ_DW = 16;

    typedef enum logic [1:0] {
        MC_NULL  = 2'b00,
        MC_DATA  = 2'b01,
        MC_PILOT = 2'b10,
        MC_RSVD  = 2'b11
    } map_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    typedef struct packed {
        logic signed [IQ_DW-1:0] i;
        logic signed [IQ_DW-1:0] q;
    } iq_t;

endpackage

`default_nettype wire

// File: rtl/pilot_prbs.sv
// ============================================================================
// pilot_prbs : x^11+x^2+1 Fibonacci LFSR giving the BPSK pilot sign
// Rev 1.0
// ============================================================================
`default_nettype none

module pilot_prbs #(
    parameter logic [10:0] SEED = 11'h7FF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic advance,
    output logic neg
);

    logic [10:0] r_lfsr;

    // Load wins over advance so a pilot on the last bin never corrupts the next seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2], r_lfsr[10:1]};
        end
    end

    assign neg = r_lfsr[0];

endmodule

`default_nettype wire

// File: rtl/ofdm_subcarrier_mapper.sv
// ============================================================================
// ofdm_subcarrier_mapper : walks map ROM bins and builds the IFFT input stream
// Rev 1.0
// ============================================================================
`default_nettype none

module ofdm_subcarrier_mapper
    import map_pkg::*;
#(
    parameter int                   DW        = 16,
    parameter int                   FFTSIZE   = 1024,
    parameter int                   ADDR_W    = 10,
    parameter logic signed [DW-1:0] PILOT_AMP = 16'sd11585,
    parameter logic [10:0]          PRBS_SEED = 11'h7FF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2:0]           index_bw,
    output logic [2:0]           map_index_bw,
    output logic [ADDR_W-1:0]    map_addr,
    input  logic [1:0]           map_code,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [ADDR_W-1:0]    out_bin,
    output logic                 busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_bin;
    logic [ADDR_W-1:0]     w_bin_inc;
    map_code_t             w_code;
    logic                  w_run;
    logic                  w_out_free;
    logic                  w_adv;
    logic                  w_last_bin;
    logic                  w_start;
    logic                  w_wrap_load;
    logic                  w_pilot_neg;
    logic signed [DW-1:0]  w_smp_i;
    logic signed [DW-1:0]  w_smp_q;

    assign w_code      = map_code_t'(map_code);
    assign w_run       = (r_state == ST_RUN);
    assign w_out_free  = !out_valid || out_ready;
    assign w_adv       = w_run && w_out_free && ((w_code != MC_DATA) || in_valid);
    assign w_last_bin  = (r_bin == ADDR_W'(FFTSIZE - 1));
    assign w_bin_inc   = w_last_bin ? '0 : r_bin + ADDR_W'(1);
    assign w_start     = (r_state == ST_IDLE) && en;
    assign w_wrap_load = w_adv && w_last_bin && en;

    // Lookahead keeps the registered ROM output aligned with r_bin, stalled or not.
    assign map_addr = w_adv ? w_bin_inc : r_bin;
    assign in_ready = w_run && (w_code == MC_DATA) && w_out_free;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (en) w_state_nxt = ST_PRIME;
            ST_PRIME: w_state_nxt = ST_RUN;
            ST_RUN:   if (w_adv && w_last_bin && !en) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin        <= '0;
            map_index_bw <= '0;
        end else begin
            if (w_adv) begin
                r_bin <= w_bin_inc;
            end
            if (w_start || w_wrap_load) begin
                map_index_bw <= index_bw;
            end
        end
    end

    pilot_prbs #(
        .SEED (PRBS_SEED)
    ) u_pilot_prbs (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_start || w_wrap_load),
        .advance (w_adv && (w_code == MC_PILOT)),
        .neg     (w_pilot_neg)
    );

    // Null and reserved/DC bins both fall through to zero.
    always_comb begin
        w_smp_i = '0;
        w_smp_q = '0;
        case (w_code)
            MC_DATA: begin
                w_smp_i = in_i;
                w_smp_q = in_q;
            end
            MC_PILOT: begin
                w_smp_i = w_pilot_neg ? -PILOT_AMP : PILOT_AMP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_bin   <= '0;
            out_last  <= 1'b0;
        end else if (w_adv) begin
            out_valid <= 1'b1;
            out_i     <= w_smp_i;
            out_q     <= w_smp_q;
            out_bin   <= r_bin;
            out_last  <= w_last_bin;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ofdm_subcarrier_mapper.sv
// ============================================================================
// tb_ofdm_subcarrier_mapper : directed + randomized bench for the bin mapper
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ofdm_subcarrier_mapper;

    localparam int DW      = 16;
    localparam int FFTSIZE = 8;
    localparam int ADDR_W  = 3;
    localparam logic signed [15:0] A = 16'sd11585;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic [2:0]         bin;
        logic               last;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [2:0]           index_bw;
    logic [2:0]           map_index_bw;
    logic [ADDR_W-1:0]    map_addr;
    logic [1:0]           map_code;
    logic signed [DW-1:0] in_i;
    logic signed [DW-1:0] in_q;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_i;
    logic signed [DW-1:0] out_q;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [ADDR_W-1:0]    out_bin;
    logic                 busy;

    ofdm_subcarrier_mapper #(
        .DW      (DW),
        .FFTSIZE (FFTSIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .index_bw     (index_bw),
        .map_index_bw (map_index_bw),
        .map_addr     (map_addr),
        .map_code     (map_code),
        .in_i         (in_i),
        .in_q         (in_q),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_bin      (out_bin),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Registered map ROM: code appears one cycle after its address.
    logic [1:0] rom [8][8];
    always @(posedge clk) map_code <= rom[map_index_bw][map_addr];

    logic signed [15:0] src_i [512];
    logic signed [15:0] src_q [512];
    int    src_rd, src_wr, mdl_rd;
    item_t exp_q[$];
    item_t got_q[$];
    int    got_cyc[$];
    int    cyc, first_valid;
    logic  in_fire;
    int    n_vec, n_err;
    logic signed [15:0] hold_i, hold_q;
    logic [2:0]         hold_bin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic add_samples(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            src_i[src_wr] = rnd ? 16'($urandom) : 16'(src_wr + 1);
            src_q[src_wr] = rnd ? 16'($urandom) : 16'(100 + src_wr);
            src_wr++;
        end
    endtask

    // Expected symbol: walk the map, data pulls the next source sample,
    // pilots take their sign from the bit-0 of an LFSR restarted at 0x7FF.
    task automatic model_symbol(input int bw);
        int    l;
        item_t it;
        l = 'h7FF;
        for (int b = 0; b < FFTSIZE; b++) begin
            it.i    = '0;
            it.q    = '0;
            it.bin  = 3'(b);
            it.last = (b == FFTSIZE - 1);
            case (rom[bw][b])
                2'b01: begin
                    it.i = src_i[mdl_rd];
                    it.q = src_q[mdl_rd];
                    mdl_rd++;
                end
                2'b10: begin
                    it.i = (l % 2 == 1) ? -A : A;
                    l    = (l / 2) + (((l ^ (l / 4)) % 2) * 1024);
                end
                default: ;
            endcase
            exp_q.push_back(it);
        end
    endtask

    task automatic start_run();
        cyc         = 0;
        first_valid = -1;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drive(input logic e, input logic iv, input logic ordy, input logic [2:0] bw);
        item_t it;
        en        = e;
        index_bw  = bw;
        out_ready = ordy;
        in_valid  = iv && (src_rd < src_wr);
        in_i      = src_i[src_rd];
        in_q      = src_q[src_rd];
        @(negedge clk);
        in_fire = in_valid && in_ready;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            it.i = out_i; it.q = out_q; it.bin = out_bin; it.last = out_last;
            got_q.push_back(it);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic edge_done();
        @(posedge clk);
        #1;
        if (in_fire) src_rd++;
        cyc++;
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_i[%0d]", tag, k), 32'(got_q[k].i), 32'(exp_q[k].i));
            check($sformatf("%s_q[%0d]", tag, k), 32'(got_q[k].q), 32'(exp_q[k].q));
            check($sformatf("%s_bin[%0d]", tag, k), 32'(got_q[k].bin), 32'(exp_q[k].bin));
            check($sformatf("%s_last[%0d]", tag, k), 32'(got_q[k].last), 32'(exp_q[k].last));
        end
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_i"}, 32'(out_i), 0);
        check({tag, "_out_q"}, 32'(out_q), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_out_bin"}, 32'(out_bin), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_map_addr"}, 32'(map_addr), 0);
        check({tag, "_map_index_bw"}, 32'(map_index_bw), 0);
    endtask

    initial begin
        logic [15:0] m0, m3;
        n_vec = 0; n_err = 0;
        src_rd = 0; src_wr = 0; mdl_rd = 0;
        en = 0; index_bw = 0; in_valid = 0; out_ready = 1; in_i = 0; in_q = 0;
        in_fire = 0; hold_i = 0; hold_q = 0; hold_bin = 0;
        rst_n = 0;
        m0 = {2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        m3 = {2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 8; w++) rom[w][b] = 2'b00;
            rom[0][b] = m0[2*b +: 2];
            rom[2][b] = m0[2*b +: 2];
            rom[3][b] = m3[2*b +: 2];
            rom[5][b] = 2'b10;
        end

        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset");
        check("reset_in_ready", 32'(in_ready), 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Basic symbol, en pulsed once.
        add_samples(3, 0);
        model_symbol(0);
        start_run();
        for (int s = 0; s < 14; s++) begin
            drive(s == 0, 1'b1, 1'b1, 3'd0);
            edge_done();
        end
        check("basic_latency", 32'(first_valid), 3);
        check("basic_idle", 32'(busy), 0);
        compare_all("basic");

        // Input starvation on bin 2.
        add_samples(3, 1);
        model_symbol(0);
        start_run();
        for (int s = 0; s < 18; s++) begin
            drive(s == 0, !(s >= 4 && s <= 6), 1'b1, 3'd0);
            if (s >= 4 && s <= 6) check($sformatf("stall_addr[%0d]", s), 32'(map_addr), 2);
            if (s == 7) check("stall_addr_resume", 32'(map_addr), 3);
            edge_done();
        end
        if (got_cyc.size() == 8) check("stall_span", 32'(got_cyc[7] - got_cyc[0]), 10);
        compare_all("stall");

        // Output backpressure.
        add_samples(3, 1);
        model_symbol(0);
        start_run();
        for (int s = 0; s < 18; s++) begin
            drive(s == 0, 1'b1, !(s >= 5 && s <= 8), 3'd0);
            if (s == 5) begin
                hold_i = out_i; hold_q = out_q; hold_bin = out_bin;
                check("bp_valid", 32'(out_valid), 1);
            end
            if (s >= 5 && s <= 8) check($sformatf("bp_in_ready[%0d]", s), 32'(in_ready), 0);
            if (s >= 6 && s <= 8) begin
                check($sformatf("bp_hold_i[%0d]", s), 32'(out_i), 32'(hold_i));
                check($sformatf("bp_hold_q[%0d]", s), 32'(out_q), 32'(hold_q));
                check($sformatf("bp_hold_bin[%0d]", s), 32'(out_bin), 32'(hold_bin));
            end
            edge_done();
        end
        compare_all("bp");

        // Two back-to-back symbols, bandwidth request changed mid-symbol.
        add_samples(6, 1);
        model_symbol(0);
        model_symbol(3);
        start_run();
        for (int s = 0; s < 24; s++) begin
            drive(s < 12, 1'b1, 1'b1, (s >= 5) ? 3'd3 : 3'd0);
            if (s >= 2 && s <= 9) check($sformatf("bw_old[%0d]", s), 32'(map_index_bw), 0);
            if (s >= 10 && s <= 16) check($sformatf("bw_new[%0d]", s), 32'(map_index_bw), 3);
            edge_done();
        end
        if (got_cyc.size() == 16) check("wrap_gap", 32'(got_cyc[8] - got_cyc[7]), 1);
        compare_all("twosym");

        // All-pilot map.
        model_symbol(5);
        start_run();
        for (int s = 0; s < 14; s++) begin
            drive(s == 0, 1'b1, 1'b1, 3'd5);
            edge_done();
        end
        if (got_q.size() > 0) check("pilot_first_neg", 32'(got_q[0].i), 32'(-A));
        compare_all("pilot");

        // Asynchronous reset in the middle of a symbol.
        add_samples(3, 1);
        start_run();
        for (int s = 0; s < 8; s++) begin
            drive(s == 0, 1'b1, 1'b1, 3'd2);
            if (s == 7) begin
                check("rst_at_bin", 32'(out_bin), 4);
                #2;
                rst_n = 0;
                #1;
                check_reset_state("midrst");
            end
            edge_done();
        end
        @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        mdl_rd = src_rd;
        add_samples(3, 1);
        model_symbol(0);
        start_run();
        for (int s = 0; s < 14; s++) begin
            drive(s == 0, 1'b1, 1'b1, 3'd0);
            edge_done();
        end
        compare_all("restart");

        // Randomized maps, samples and handshakes.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 8; b++) rom[1][b] = 2'($urandom_range(0, 3));
            add_samples(8, 1);
            model_symbol(1);
            start_run();
            for (int s = 0; s < 60; s++) begin
                drive(s == 0, ($urandom_range(0, 3) != 0) || s >= 50,
                      ($urandom_range(0, 3) != 0) || s >= 50, 3'd1);
                edge_done();
            end
            mdl_rd = src_rd;
            compare_all($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
